// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned LANES   = WORD_W / BYTE_W;
  localparam int unsigned LANE_W  = 2;
  localparam int unsigned HDR_LEN = 2;
  localparam int unsigned CNT_W   = BYTE_W * HDR_LEN;

  typedef enum logic [2:0] {
    ST_LEN_LO = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// Packs four accepted bytes (little-endian) into one 32-bit word and pulses
// o_word_valid for one cycle after the fourth byte.
module imem_loader_byte_to_word_packer
  import imem_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_byte_valid,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_last_lane_c,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word
);

  logic [LANE_W-1:0]        lane_q;
  logic [WORD_W-BYTE_W-1:0] asm_q;

  assign o_last_lane_c = (lane_q == LANE_W'(LANES - 1));

  // Lanes 0..2 are staged; lane 3 completes the word straight into o_word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      lane_q       <= '0;
      asm_q        <= '0;
      o_word_valid <= 1'b0;
      o_word       <= '0;
    end else begin
      o_word_valid <= 1'b0;
      if (i_byte_valid) begin
        lane_q <= lane_q + 1'b1;
        if (o_last_lane_c) begin
          o_word_valid <= 1'b1;
          o_word       <= {i_byte, asm_q};
        end else begin
          case (lane_q)
            2'd0:    asm_q[7:0]   <= i_byte;
            2'd1:    asm_q[15:8]  <= i_byte;
            default: asm_q[23:16] <= i_byte;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: receives a length-prefixed, XOR-checked
// byte stream and holds the core in reset until the image is verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_valid,
  input  logic [BYTE_W-1:0] i_rx_data,
  output logic              o_rx_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wdata,
  output logic              o_core_reset,
  output logic              o_done,
  output logic              o_error
);

  localparam int unsigned MAX_WORDS = (2 ** ADDR_W) / 4;
  localparam int unsigned CMP_W     = CNT_W + 1;

  loader_state_t     state_q, state_nxt;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  word_idx_q;
  logic [BYTE_W-1:0] csum_q;
  logic [CNT_W-1:0]  len_c;
  logic              rx_fire_c;
  logic              data_fire_c;
  logic              last_lane_c;
  logic              last_word_c;

  assign rx_fire_c   = i_rx_valid & o_rx_ready;
  assign data_fire_c = rx_fire_c && (state_q == ST_DATA);
  assign len_c       = {i_rx_data, count_q[BYTE_W-1:0]};
  assign last_word_c = (word_idx_q == count_q - 1'b1);

  imem_loader_byte_to_word_packer u_packer (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_byte_valid  (data_fire_c),
    .i_byte        (i_rx_data),
    .o_last_lane_c (last_lane_c),
    .o_word_valid  (o_mem_we),
    .o_word        (o_mem_wdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_LEN_LO;
    else         state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_LEN_LO: if (rx_fire_c) state_nxt = ST_LEN_HI;
      ST_LEN_HI: begin
        if (rx_fire_c) begin
          if ({1'b0, len_c} > CMP_W'(MAX_WORDS)) state_nxt = ST_ERROR;
          else if (len_c == '0)                  state_nxt = ST_CSUM;
          else                                   state_nxt = ST_DATA;
        end
      end
      ST_DATA:   if (data_fire_c && last_lane_c && last_word_c) state_nxt = ST_CSUM;
      ST_CSUM:   if (rx_fire_c) state_nxt = (i_rx_data == csum_q) ? ST_DONE : ST_ERROR;
      default:   state_nxt = state_q;
    endcase
  end

  // Header/payload bookkeeping; status outputs follow the next state so they
  // change in the same cycle the FSM enters DONE or ERROR.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q      <= '0;
      word_idx_q   <= '0;
      csum_q       <= '0;
      o_mem_addr   <= '0;
      o_rx_ready   <= 1'b1;
      o_core_reset <= 1'b1;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_rx_ready   <= (state_nxt != ST_DONE) && (state_nxt != ST_ERROR);
      o_core_reset <= (state_nxt != ST_DONE);
      o_done       <= (state_nxt == ST_DONE);
      o_error      <= (state_nxt == ST_ERROR);
      if (rx_fire_c) begin
        case (state_q)
          ST_LEN_LO: begin
            count_q[BYTE_W-1:0] <= i_rx_data;
            csum_q              <= csum_q ^ i_rx_data;
          end
          ST_LEN_HI: begin
            count_q[CNT_W-1:BYTE_W] <= i_rx_data;
            csum_q                  <= csum_q ^ i_rx_data;
          end
          ST_DATA: begin
            csum_q <= csum_q ^ i_rx_data;
            if (last_lane_c) begin
              o_mem_addr <= ADDR_W'({word_idx_q, 2'b00});
              word_idx_q <= word_idx_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as frames are
// driven and retired by a monitor watching the memory write strobe.
module tb_imem_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        o_rx_ready;
  logic        o_mem_we;
  logic [7:0]  o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_core_reset;
  logic        o_done;
  logic        o_error;

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;
  int strobe_base = 0;
  logic prev_we = 1'b0;
  wr_t exp_q[$];
  logic [31:0] frame_words[$];

  imem_loader #(.ADDR_W(8)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .o_rx_ready   (o_rx_ready),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_core_reset (o_core_reset),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Retire expected writes on every strobe; flag strobes held two cycles.
  always @(negedge i_clk) begin
    if (o_mem_we) begin
      wr_t e;
      strobe_cnt++;
      if (prev_we) check("we_double", 32'(1), 32'(0));
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(o_mem_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(o_mem_addr), e.addr);
        check("wr_data", o_mem_wdata, e.data);
      end
    end
    prev_we <= o_mem_we;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge i_clk);
    i_reset    = 1'b1;
    i_rx_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    strobe_base = strobe_cnt;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge i_clk);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    while (!o_rx_ready && guard < 20) begin
      @(negedge i_clk);
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 32'(o_rx_ready), 32'(1));
    @(posedge i_clk);
  endtask

  task automatic idle(input int n);
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    repeat (n) @(posedge i_clk);
  endtask

  // Drives a frame from frame_words; corrupt flips bit 0 of the checksum.
  task automatic send_frame(input int len, input bit corrupt, input bit bubble);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'(len) ^ 8'(len >> 8);
    for (int i = 0; i < frame_words.size(); i++)
      exp_q.push_back('{addr: 32'(i * 4), data: frame_words[i]});
    send_byte(8'(len));
    if (bubble) idle(1);
    send_byte(8'(len >> 8));
    for (int i = 0; i < frame_words.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        b  = 8'(frame_words[i] >> (8 * k));
        cs = cs ^ b;
        if (bubble) idle(1);
        send_byte(b);
      end
    end
    if (bubble) idle(1);
    send_byte(cs ^ 8'(corrupt));
    idle(4);
  endtask

  task automatic check_end(input string tag, input bit ok, input int writes);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'(0));
    check({tag, "_writes"},  32'(strobe_cnt - strobe_base), 32'(writes));
    check({tag, "_done"},    32'(o_done), 32'(ok));
    check({tag, "_error"},   32'(o_error), 32'(!ok));
    check({tag, "_core_rst"}, 32'(o_core_reset), 32'(!ok));
    check({tag, "_ready"},   32'(o_rx_ready), 32'(0));
  endtask

  initial begin
    // Reset with no input.
    do_reset();
    idle(5);
    check("rst_core_reset", 32'(o_core_reset), 32'(1));
    check("rst_ready", 32'(o_rx_ready), 32'(1));
    check("rst_done", 32'(o_done), 32'(0));
    check("rst_error", 32'(o_error), 32'(0));
    check("rst_addr", 32'(o_mem_addr), 32'(0));
    check("rst_wdata", o_mem_wdata, 32'(0));
    check("rst_writes", 32'(strobe_cnt), 32'(0));

    // Two-word image, good checksum (C3).
    frame_words = '{32'h0050_0093, 32'h0010_0113};
    send_frame(2, 1'b0, 1'b0);
    check_end("good2", 1'b1, 2);

    // Same image, checksum C2.
    do_reset();
    send_frame(2, 1'b1, 1'b0);
    check_end("badcs2", 1'b0, 2);

    // Oversize: 65 words.
    do_reset();
    send_byte(8'h41);
    send_byte(8'h00);
    idle(3);
    check_end("oversize", 1'b0, 0);

    // Empty image, good and bad checksum.
    frame_words = {};
    do_reset();
    send_frame(0, 1'b0, 1'b0);
    check_end("empty_ok", 1'b1, 0);
    do_reset();
    send_frame(0, 1'b1, 1'b0);
    check_end("empty_bad", 1'b0, 0);

    // Full-capacity image of random words.
    do_reset();
    for (int i = 0; i < 64; i++) frame_words.push_back($urandom);
    send_frame(64, 1'b0, 1'b0);
    check_end("full64", 1'b1, 64);
    frame_words = {};

    // Bubbled stream, reset in the middle of the second word.
    do_reset();
    exp_q.push_back('{addr: 32'h0, data: 32'h0050_0093});
    begin
      logic [7:0] part[8];
      part = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01};
      for (int i = 0; i < 8; i++) begin
        send_byte(part[i]);
        idle(1);
      end
    end
    idle(2);
    check("midrst_pending", 32'(exp_q.size()), 32'(0));
    check("midrst_writes", 32'(strobe_cnt - strobe_base), 32'(1));
    check("midrst_done", 32'(o_done), 32'(0));
    do_reset();
    check("midrst_after_ready", 32'(o_rx_ready), 32'(1));
    check("midrst_after_core", 32'(o_core_reset), 32'(1));
    frame_words = '{32'h0050_0093, 32'h0010_0113};
    send_frame(2, 1'b0, 1'b1);
    check_end("reload", 1'b1, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the core's instruction memory; the write-side counterpart to the fetch stage's read-only port.
- Accepts a byte stream over a valid/ready handshake, framed as: 16-bit word count, little-endian payload words, XOR checksum.
- Drives the instruction memory write port word by word.
- Holds the core in reset until the image is loaded and verified.

Parameters:
- ADDR_W, 8, byte-address width of instruction memory. Capacity MAX_WORDS = 2^ADDR_W/4 (64 at default).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_rx_valid  in  1  byte available on i_rx_data
- i_rx_data  in  8  stream byte
- o_rx_ready  out  1  loader can accept a byte; transfer occurs when i_rx_valid & o_rx_ready
- o_mem_we  out  1  one-cycle write strobe to instruction memory
- o_mem_addr  out  ADDR_W  byte address of the word being written (multiple of 4)
- o_mem_wdata  out  32  assembled little-endian word
- o_core_reset  out  1  held high until load completes successfully
- o_done  out  1  image loaded and checksum matched
- o_error  out  1  oversize image or checksum mismatch

Behaviour:
- Clock and reset: clock i_clk; reset i_reset, synchronous, active-high.
- Reset values: state=LEN_LO, o_rx_ready=1, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_core_reset=1, o_done=0, o_error=0. Internal counters, byte lane index and checksum all reset to 0.
- Reset mid-load: abandons the load, returns to LEN_LO, and leaves memory contents as-is.
- Frame format: len_lo, len_hi, N×4 payload bytes (byte 0 = bits[7:0] of the word), then one checksum byte.
- Checksum: XOR of every byte from len_lo through the last payload byte.
- States:
  - LEN_LO: on transfer, latch count[7:0] → LEN_HI.
  - LEN_HI: on transfer, latch count[15:8]. If count > MAX_WORDS → ERROR. Else if count == 0 → CSUM. Else → DATA.
  - DATA: each transfer fills lane (0..3) of the word assembly register. On lane 3, the next cycle drives o_mem_we=1 with o_mem_wdata = assembled word and o_mem_addr = word_idx×4. word_idx then increments, with o_mem_addr wrapping modulo 2^ADDR_W (only reachable when count == MAX_WORDS). After the last word's byte 3 → CSUM.
  - CSUM: on transfer, compare the byte with the running XOR. Equal → DONE, else → ERROR.
  - DONE: o_rx_ready=0, o_core_reset=0, o_done=1. Terminal until i_reset.
  - ERROR: o_rx_ready=0, o_core_reset=1, o_error=1. Terminal until i_reset.
- Throughput: o_rx_ready stays 1 throughout LEN_LO..CSUM, so one byte per cycle is sustained. A write strobe overlaps acceptance of the next word's byte 0.
- Write strobe: o_mem_we is never high for more than one cycle per word. Exactly count strobes are issued per successful frame.
- Gaps: i_rx_valid low at any point simply stalls; no timeout.
- o_mem_addr and o_mem_wdata hold their last values between strobes.
- o_core_reset deasserts in the same cycle o_done asserts, and never before the final write strobe has been issued.

Decomposition:
- Shared package constants: loader state encoding (LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR), word width 32, frame header length 2.
- One sub-module is natural: byte_to_word_packer. It holds the lane counter and the 32-bit assembly register, and emits a word-valid pulse with the packed word.
- The FSM, address counter and checksum stay in imem_loader.

Test Plan:
- Reset, then no input → o_core_reset=1, o_rx_ready=1, o_done=0, o_error=0, o_mem_we never asserts.
- Stream 02 00 93 00 50 00 13 01 10 00 C3 back-to-back:
  - strobe at addr 0x00, data 0x00500093;
  - strobe at addr 0x04, data 0x00100113;
  - then o_done=1, o_core_reset=0, o_rx_ready=0.
- Same stream with checksum byte C2 → both writes still issued, then o_error=1, o_core_reset stays 1, o_done=0.
- Length 41 00 (65 words, ADDR_W=8) → o_error=1 after the second byte, no write strobes.
- Length 00 00 with checksum 00 → o_done=1 with zero writes. With checksum 01 → o_error=1.
- Valid-bubble stream (valid toggling every other cycle) of the two-word image, then i_reset asserted mid-second-word → first word written at addr 0x00; after reset, state returns to LEN_LO and a fresh full frame loads correctly.
